io_interrupt_unit: RTL and testbench
====================================

// Module: io_interrupt_unit
// PURPOSE
//  Owns the I/O flags and the interrupt cycle for the basic computer. Holds INPR/OUTR, FGI/FGO, IEN and R.
//  Sits beside the control unit: feeds it FGI, FGO, IEN and R (int_req), and consumes its I/O micro-ops.
//  While R=1 it drives the RT0..RT2 interrupt micro-ops in place of the fetch micro-ops.
// PARAMETERS
//  IO_WIDTH   8   width of INPR, OUTR and the device data buses
//  DATA_WIDTH 16  width of the AC input; OUTR takes the low IO_WIDTH bits
// PORTS
//  CLK          in   1           system clock, all state on rising edge
//  RST_N        in   1           asynchronous active-low reset
//  T            in   16          one-hot sequence timing from TDECODER
//  AC           in   DATA_WIDTH  accumulator value, source for OUTR
//  set_IEN      in   1           ION micro-op
//  clrIEN       in   1           IOF micro-op
//  clrFGI       in   1           INP micro-op, consume INPR
//  ldOUTR       in   1           OUT micro-op, OUTR<=AC[IO_WIDTH-1:0]
//  in_valid     in   1           input device offers in_data
//  in_data      in   IO_WIDTH    input device byte
//  in_ready     out  1           =~FGI
//  out_valid    out  1           =~FGO (OUTR holds an unsent byte)
//  out_data     out  IO_WIDTH    =OUTR
//  out_ready    in   1           output device accepts out_data
//  INPR         out  IO_WIDTH    input register, to AC low bits
//  FGI, FGO, IEN out 1           flag flip-flops
//  R            out  1           interrupt pending / in progress (int_req)
//  int_s        out  3           bus select during RT0..RT2, else 3'b000
//  int_clrAR, int_ldTR, int_memwrite, int_clrPC, int_inrPC, int_INC, int_CLR  out 1  interrupt micro-ops
// BEHAVIOUR
//  Reset (async, RST_N=0): INPR=0, OUTR=0, FGI=0, FGO=1, IEN=0, R=0, all int_* = 0.
//  Input handshake: transfer when in_valid & in_ready. That edge: INPR<=in_data, FGI<=1.
//    clrFGI clears FGI next edge; clrFGI while FGI=0 has no effect.
//    A transfer and clrFGI cannot coincide, because ready=~FGI.
//  Output: ldOUTR loads OUTR and sets FGO<=0. Transfer when out_valid & out_ready sets FGO<=1.
//    ldOUTR while FGO=0 overwrites OUTR (software error, not guarded).
//    ldOUTR and a transfer in the same cycle: ldOUTR wins, FGO=0.
//  IEN: set_IEN has priority over clrIEN. RT2 clears IEN with priority over set_IEN.
//  R set: at an edge where T[0]|T[1]|T[2]=0, IEN=1 and (FGI|FGO)=1, R<=1.
//    R stays 1 until RT2; flags are sampled in the current cycle.
//  Interrupt sequence (combinational from R & T, one cycle each):
//    RT0: int_s=3'b010, int_ldTR=1, int_clrAR=1, int_INC=1        (AR<-0, TR<-PC)
//    RT1: int_s=3'b110, int_memwrite=1, int_clrPC=1, int_INC=1    (M[0]<-TR, PC<-0)
//    RT2: int_inrPC=1, int_CLR=1; edge clears R and IEN           (PC<-1, SC<-0)
//  When R=1, the CU ORs in the int_* outputs and suppresses its own T0..T2 fetch outputs.
//  Latency: R is visible on the cycle after the enabling condition. Vector entry takes 3 cycles from the next T0.
//  Reset mid-sequence: all state returns to reset values; the sequence is abandoned.
// STRUCTURE
//  Shared package: bus-select constants (SEL_AR=1, PC=2, DR=3, AC=4, IR=5, TR=6, MEM=7), IO_WIDTH default.
//  One sub-module, io_flag_port: an IO_WIDTH data register plus flag with the valid/ready rules.
//    Instanced twice (input side, output side).
//  The R/interrupt sequencer and IEN live in the top level.
// TESTING
//  1. Reset: RST_N=0 mid-cycle -> FGI=0, FGO=1, IEN=0, R=0, out_valid=0, in_ready=1, int_s=0.
//  2. Input: in_valid=1, in_data=8'hA5 -> INPR=8'hA5, FGI=1, in_ready=0; clrFGI pulse -> FGI=0.
//  3. Output: AC=16'h1234 with ldOUTR -> out_data=8'h34, out_valid=1.
//     out_ready held 0 for 3 cycles: data stable. Then out_ready=1 -> FGO=1, out_valid=0.
//  4. Interrupt: IEN=1, FGI=1 at T4 -> R=1 next cycle. At T0/T1/T2: int_s=2/6/0, ldTR, memwrite, inrPC as listed.
//     After RT2: R=0, IEN=0.
//  5. Priority: set_IEN & clrIEN same cycle -> IEN=1. set_IEN during RT2 -> IEN=0. IEN=0 with FGI=1 -> R stays 0.
//  6. Reset asserted during RT1 -> R=0 immediately; no int_memwrite after release.

Source files
------------

// File: rtl/io_interrupt_unit_pkg.sv
// Shared constants for the I/O and interrupt unit: bus-select codes and default widths.
package io_interrupt_unit_pkg;

  localparam int unsigned IO_WIDTH_DEFAULT   = 8;
  localparam int unsigned DATA_WIDTH_DEFAULT = 16;

  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_AR   = 3'd1;
  localparam logic [2:0] SEL_PC   = 3'd2;
  localparam logic [2:0] SEL_DR   = 3'd3;
  localparam logic [2:0] SEL_AC   = 3'd4;
  localparam logic [2:0] SEL_IR   = 3'd5;
  localparam logic [2:0] SEL_TR   = 3'd6;
  localparam logic [2:0] SEL_MEM  = 3'd7;

endpackage

// File: rtl/io_flag_port.sv
// Data register plus a "full" flag: a write loads the register and marks it full,
// a read marks it empty. A write in the same cycle as a read wins.
module io_flag_port #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      full <= 1'b0;
      data <= '0;
    end else if (wr_en) begin
      full <= 1'b1;
      data <= wr_data;
    end else if (rd_en) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/io_interrupt_unit.sv
// I/O flags, INPR/OUTR and the interrupt cycle (R, IEN, RT0..RT2 micro-ops) for the basic computer.
module io_interrupt_unit
  import io_interrupt_unit_pkg::*;
#(
  parameter int unsigned IO_WIDTH   = IO_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [15:0]           T,
  input  logic [DATA_WIDTH-1:0] AC,
  input  logic                  set_IEN,
  input  logic                  clrIEN,
  input  logic                  clrFGI,
  input  logic                  ldOUTR,
  input  logic                  in_valid,
  input  logic [IO_WIDTH-1:0]   in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [IO_WIDTH-1:0]   out_data,
  input  logic                  out_ready,
  output logic [IO_WIDTH-1:0]   INPR,
  output logic                  FGI,
  output logic                  FGO,
  output logic                  IEN,
  output logic                  R,
  output logic [2:0]            int_s,
  output logic                  int_clrAR,
  output logic                  int_ldTR,
  output logic                  int_memwrite,
  output logic                  int_clrPC,
  output logic                  int_inrPC,
  output logic                  int_INC,
  output logic                  int_CLR
);

  logic in_full, out_full;
  logic rt0, rt1, rt2;
  logic unused_bits;

  assign unused_bits = ^{AC[DATA_WIDTH-1:IO_WIDTH], T[15:3]};

  io_flag_port #(.WIDTH(IO_WIDTH)) u_in_port (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .wr_en   (in_valid & ~in_full),
    .wr_data (in_data),
    .rd_en   (clrFGI),
    .full    (in_full),
    .data    (INPR)
  );

  // Output side stores "OUTR holds an unsent byte", which is the inverse of FGO.
  io_flag_port #(.WIDTH(IO_WIDTH)) u_out_port (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .wr_en   (ldOUTR),
    .wr_data (AC[IO_WIDTH-1:0]),
    .rd_en   (out_full & out_ready),
    .full    (out_full),
    .data    (out_data)
  );

  assign FGI       = in_full;
  assign FGO       = ~out_full;
  assign in_ready  = ~in_full;
  assign out_valid = out_full;

  assign rt0 = R & T[0];
  assign rt1 = R & T[1];
  assign rt2 = R & T[2];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      IEN <= 1'b0;
      R   <= 1'b0;
    end else begin
      if (rt2) begin
        IEN <= 1'b0;
      end else if (set_IEN) begin
        IEN <= 1'b1;
      end else if (clrIEN) begin
        IEN <= 1'b0;
      end
      // Never raise R inside a fetch phase, so the sequence always starts at a clean T0.
      if (rt2) begin
        R <= 1'b0;
      end else if (~|T[2:0] && IEN && (FGI || FGO)) begin
        R <= 1'b1;
      end
    end
  end

  always_comb begin
    int_s        = SEL_NONE;
    int_clrAR    = 1'b0;
    int_ldTR     = 1'b0;
    int_memwrite = 1'b0;
    int_clrPC    = 1'b0;
    int_inrPC    = 1'b0;
    int_INC      = 1'b0;
    int_CLR      = 1'b0;
    if (rt0) begin
      int_s     = SEL_PC;
      int_ldTR  = 1'b1;
      int_clrAR = 1'b1;
      int_INC   = 1'b1;
    end else if (rt1) begin
      int_s        = SEL_TR;
      int_memwrite = 1'b1;
      int_clrPC    = 1'b1;
      int_INC      = 1'b1;
    end else if (rt2) begin
      int_inrPC = 1'b1;
      int_CLR   = 1'b1;
    end
  end

endmodule

// File: tb/tb_io_interrupt_unit.sv
// Scoreboard bench for io_interrupt_unit: expected observations are queued with the stimulus
// and popped when the DUT outputs are sampled.
module tb_io_interrupt_unit;

  typedef struct packed {
    logic [7:0] inpr;
    logic [7:0] out_data;
    logic       fgi, fgo, ien, r, in_ready, out_valid;
    logic [2:0] int_s;
    logic       clr_ar, ld_tr, memwrite, clr_pc, inr_pc, inc, clr;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  exp;
  } sb_t;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [15:0] T = 16'h0010;
  logic [15:0] AC = '0;
  logic        set_IEN = 1'b0, clrIEN = 1'b0, clrFGI = 1'b0, ldOUTR = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, out_valid, FGI, FGO, IEN, R;
  logic [7:0]  out_data, INPR;
  logic [2:0]  int_s;
  logic        int_clrAR, int_ldTR, int_memwrite, int_clrPC, int_inrPC, int_INC, int_CLR;

  int   n_checks = 0;
  int   n_errors = 0;
  sb_t  sb_q[$];
  obs_t e;
  obs_t e_rst;

  io_interrupt_unit #(.IO_WIDTH(8), .DATA_WIDTH(16)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .T            (T),
    .AC           (AC),
    .set_IEN      (set_IEN),
    .clrIEN       (clrIEN),
    .clrFGI       (clrFGI),
    .ldOUTR       (ldOUTR),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .INPR         (INPR),
    .FGI          (FGI),
    .FGO          (FGO),
    .IEN          (IEN),
    .R            (R),
    .int_s        (int_s),
    .int_clrAR    (int_clrAR),
    .int_ldTR     (int_ldTR),
    .int_memwrite (int_memwrite),
    .int_clrPC    (int_clrPC),
    .int_inrPC    (int_inrPC),
    .int_INC      (int_INC),
    .int_CLR      (int_CLR)
  );

  always #5 CLK = ~CLK;

  function automatic obs_t observe();
    obs_t o;
    o.inpr = INPR;          o.out_data = out_data;
    o.fgi = FGI;            o.fgo = FGO;
    o.ien = IEN;            o.r = R;
    o.in_ready = in_ready;  o.out_valid = out_valid;
    o.int_s = int_s;        o.clr_ar = int_clrAR;
    o.ld_tr = int_ldTR;     o.memwrite = int_memwrite;
    o.clr_pc = int_clrPC;   o.inr_pc = int_inrPC;
    o.inc = int_INC;        o.clr = int_CLR;
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag);
    sb_t s;
    s.tag = tag;
    s.exp = e;
    sb_q.push_back(s);
  endtask

  task automatic sample();
    sb_t s;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL sb_empty: got no queued expectation, required one");
    end else begin
      s = sb_q.pop_front();
      check(s.tag, observe(), s.exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] tsel(input int n);
    logic [15:0] one;
    one = 16'h0001;
    return one << n;
  endfunction

  initial begin
    e_rst = '0;
    e_rst.fgo = 1'b1;
    e_rst.in_ready = 1'b1;

    // 1. Reset asserted mid-cycle, before any clock edge
    #3 RST_N = 1'b0;
    e = e_rst; push("reset"); #1; sample();
    @(negedge CLK) RST_N = 1'b1;

    // 2. Input handshake
    in_valid = 1'b1; in_data = 8'hA5;
    e.inpr = 8'hA5; e.fgi = 1'b1; e.in_ready = 1'b0;
    push("in_xfer"); cyc(); sample();
    in_data = 8'h5A;
    push("in_blocked"); cyc(); sample();
    in_valid = 1'b0; clrFGI = 1'b1;
    e.fgi = 1'b0; e.in_ready = 1'b1;
    push("clr_fgi"); cyc(); sample();
    push("clr_fgi_idle"); cyc(); sample();
    clrFGI = 1'b0;

    // 3. Output handshake
    AC = 16'h1234; ldOUTR = 1'b1;
    e.out_data = 8'h34; e.fgo = 1'b0; e.out_valid = 1'b1;
    push("ld_outr"); cyc(); sample();
    ldOUTR = 1'b0; AC = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      push("out_hold"); cyc(); sample();
    end
    out_ready = 1'b1;
    e.fgo = 1'b1; e.out_valid = 1'b0;
    push("out_xfer"); cyc(); sample();
    out_ready = 1'b0; AC = 16'hBEEF; ldOUTR = 1'b1;
    e.out_data = 8'hEF; e.fgo = 1'b0; e.out_valid = 1'b1;
    push("ld_outr_2"); cyc(); sample();
    AC = 16'h00C3; out_ready = 1'b1;
    e.out_data = 8'hC3;
    push("ld_beats_xfer"); cyc(); sample();
    ldOUTR = 1'b0;
    e.fgo = 1'b1; e.out_valid = 1'b0;
    push("out_xfer_2"); cyc(); sample();
    out_ready = 1'b0;

    // 4/5. Interrupt entry with FGI pending
    in_valid = 1'b1; in_data = 8'h3C;
    e.inpr = 8'h3C; e.fgi = 1'b1; e.in_ready = 1'b0;
    push("in_xfer_2"); cyc(); sample();
    in_valid = 1'b0;
    push("no_ien_no_r"); cyc(); sample();
    set_IEN = 1'b1; clrIEN = 1'b1;
    e.ien = 1'b1;
    push("ien_prio"); cyc(); sample();
    set_IEN = 1'b0; clrIEN = 1'b0;
    e.r = 1'b1;
    push("r_set"); cyc(); sample();
    T = tsel(0);
    e.int_s = 3'd2; e.ld_tr = 1'b1; e.clr_ar = 1'b1; e.inc = 1'b1;
    push("rt0"); #1; sample();
    push("rt0_hold"); cyc(); sample();
    T = tsel(1);
    e.ld_tr = 1'b0; e.clr_ar = 1'b0;
    e.int_s = 3'd6; e.memwrite = 1'b1; e.clr_pc = 1'b1;
    push("rt1"); #1; sample();
    T = tsel(2); set_IEN = 1'b1;
    e.int_s = 3'd0; e.memwrite = 1'b0; e.clr_pc = 1'b0; e.inc = 1'b0;
    e.inr_pc = 1'b1; e.clr = 1'b1;
    push("rt2"); #1; sample();
    e.r = 1'b0; e.ien = 1'b0; e.inr_pc = 1'b0; e.clr = 1'b0;
    push("rt2_done"); cyc(); sample();
    set_IEN = 1'b0; T = tsel(3);
    push("after_rt2"); cyc(); sample();

    // 6. Reset during RT1
    T = tsel(4); set_IEN = 1'b1;
    e.ien = 1'b1;
    push("ien_again"); cyc(); sample();
    set_IEN = 1'b0;
    e.r = 1'b1;
    push("r_again"); cyc(); sample();
    T = tsel(0);
    e.int_s = 3'd2; e.ld_tr = 1'b1; e.clr_ar = 1'b1; e.inc = 1'b1;
    push("rt0_again"); cyc(); sample();
    T = tsel(1);
    e.ld_tr = 1'b0; e.clr_ar = 1'b0;
    e.int_s = 3'd6; e.memwrite = 1'b1; e.clr_pc = 1'b1;
    push("rt1_again"); #1; sample();
    #2 RST_N = 1'b0;
    e = e_rst;
    push("reset_rt1"); #1; sample();
    @(negedge CLK) RST_N = 1'b1;
    push("post_reset_rt1"); cyc(); sample();
    T = tsel(2);
    push("post_reset_t2"); cyc(); sample();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
